// File: rtl/miniled_pkg.sv
// Shared types and default constants for the MiniLED zone reader.
package miniled_pkg;

  localparam int ADDR_W_DEF    = 10;
  localparam int DATA_W_DEF    = 8;
  localparam int N_ZONES_DEF   = 576;
  localparam int GROUP_DEF     = 6;
  localparam int CLK_DIV_DEF   = 2;
  localparam int LATCH_CYC_DEF = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    WAIT  = 3'd2,
    SHIFT = 3'd3,
    LATCH = 3'd4,
    DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/miniled_bit_shifter.sv
// Serialises one byte MSB first: sdo changes while sclk is low, sclk high for the
// second half of each bit; o_byte_done flags the final clk cycle of the last bit.
module miniled_bit_shifter #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_sclk,
  output logic              o_sdo,
  output logic              o_byte_done
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] r_sreg;
  logic [BIT_W-1:0]  r_bit;
  logic [DIV_W-1:0]  r_div;
  logic              r_active;
  logic              w_tick;
  logic              w_last;

  assign w_tick      = r_active && (r_div == DIV_W'(CLK_DIV - 1));
  assign w_last      = (r_bit == BIT_W'(DATA_W - 1));
  assign o_byte_done = w_tick && o_sclk && w_last;

  // Divider, sclk phase and shift register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sreg   <= '0;
      r_bit    <= '0;
      r_div    <= '0;
      r_active <= 1'b0;
      o_sclk   <= 1'b0;
      o_sdo    <= 1'b0;
    end else if (i_load) begin
      r_sreg   <= i_data;
      r_bit    <= '0;
      r_div    <= '0;
      r_active <= 1'b1;
      o_sclk   <= 1'b0;
      o_sdo    <= i_data[DATA_W-1];
    end else if (r_active) begin
      if (w_tick) begin
        r_div <= '0;
        if (!o_sclk) begin
          o_sclk <= 1'b1;
        end else begin
          o_sclk <= 1'b0;
          if (w_last) begin
            r_active <= 1'b0;
            o_sdo    <= 1'b0;
          end else begin
            r_bit  <= r_bit + BIT_W'(1);
            r_sreg <= {r_sreg[DATA_W-2:0], 1'b0};
            o_sdo  <= r_sreg[DATA_W-2];
          end
        end
      end else begin
        r_div <= r_div + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/miniled_zone_reader.sv
// Frame sequencer: reads zones 0..N_ZONES-1, shifts each out, latches every GROUP bytes.
// Optional brightness scaling is enabled by defining MINILED_BRIGHT_SCALE_EN.
module miniled_zone_reader
  import miniled_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int N_ZONES   = N_ZONES_DEF,
  parameter int GROUP     = GROUP_DEF,
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int LATCH_CYC = LATCH_CYC_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_frame_start,
  input  logic [7:0]        i_global_bright,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_sclk,
  output logic              o_sdo,
  output logic              o_latch,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_frame_drop
);

  localparam int ZC_W = ADDR_W + 1;
  localparam int GC_W = $clog2(GROUP + 1);
  localparam int LC_W = $clog2(LATCH_CYC + 1);

  state_t            r_state, w_state_nx;
  logic [ZC_W-1:0]   r_zone, w_zone_nx;
  logic [GC_W-1:0]   r_grp, w_grp_nx;
  logic [LC_W-1:0]   r_lcnt, w_lcnt_nx;
  logic [DATA_W-1:0] w_cap;
  logic              w_load;
  logic              w_byte_done;

  assign w_load       = (r_state == WAIT);
  assign o_frame_drop = i_frame_start && (r_state != IDLE);

`ifdef MINILED_BRIGHT_SCALE_EN
  logic [7:0]        r_gb;
  logic [DATA_W+7:0] w_prod;

  // Brightness is frozen for the whole frame at the accepted frame_start.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gb <= 8'd0;
    end else if ((r_state == IDLE) && i_frame_start) begin
      r_gb <= i_global_bright;
    end
  end

  assign w_prod = {8'd0, i_rd_data} * {{DATA_W{1'b0}}, r_gb};
  assign w_cap  = w_prod[DATA_W+7:8];
`else
  logic w_unused_gb;
  assign w_unused_gb = ^i_global_bright;
  assign w_cap       = i_rd_data;
`endif

  // Next-state and counter updates.
  always_comb begin
    w_state_nx = r_state;
    w_zone_nx  = r_zone;
    w_grp_nx   = r_grp;
    w_lcnt_nx  = r_lcnt;
    case (r_state)
      IDLE: begin
        if (i_frame_start) begin
          w_state_nx = RD;
          w_zone_nx  = '0;
          w_grp_nx   = '0;
        end else begin
          w_state_nx = IDLE;
        end
      end
      RD:   w_state_nx = WAIT;
      WAIT: w_state_nx = SHIFT;
      SHIFT: begin
        if (w_byte_done) begin
          w_zone_nx = r_zone + ZC_W'(1);
          w_grp_nx  = r_grp + GC_W'(1);
          w_lcnt_nx = '0;
          if ((w_grp_nx == GC_W'(GROUP)) || (w_zone_nx == ZC_W'(N_ZONES))) begin
            w_state_nx = LATCH;
          end else begin
            w_state_nx = RD;
          end
        end else begin
          w_state_nx = SHIFT;
        end
      end
      LATCH: begin
        if (r_lcnt == LC_W'(LATCH_CYC - 1)) begin
          w_grp_nx  = '0;
          w_lcnt_nx = '0;
          if (r_zone == ZC_W'(N_ZONES)) begin
            w_state_nx = DONE;
          end else begin
            w_state_nx = RD;
          end
        end else begin
          w_lcnt_nx = r_lcnt + LC_W'(1);
        end
      end
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_zone       <= '0;
      r_grp        <= '0;
      r_lcnt       <= '0;
      o_rd_en      <= 1'b0;
      o_rd_addr    <= '0;
      o_latch      <= 1'b0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_zone       <= w_zone_nx;
      r_grp        <= w_grp_nx;
      r_lcnt       <= w_lcnt_nx;
      o_rd_en      <= (w_state_nx == RD);
      o_latch      <= (w_state_nx == LATCH);
      o_busy       <= (w_state_nx inside {RD, WAIT, SHIFT, LATCH});
      o_frame_done <= (w_state_nx == DONE);
      if (w_state_nx == RD) begin
        o_rd_addr <= w_zone_nx[ADDR_W-1:0];
      end
    end
  end

  miniled_bit_shifter #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (w_load),
    .i_data      (w_cap),
    .o_sclk      (o_sclk),
    .o_sdo       (o_sdo),
    .o_byte_done (w_byte_done)
  );

endmodule

// File: doc/miniled_zone_reader.md
Name: miniled_zone_reader

Overview:
- Read side of the MiniLED zone-brightness RAM, which the driver's write path fills one 8-bit zone value per 10-bit write address.
- On each frame_start, reads zones 0..N_ZONES-1 in order and shifts each byte serially to the LED driver chips.
- Frames the stream as 6-byte groups, matching the six-zone light register bank, and pulses latch after each group.

Parameters:
- ADDR_W, 10, RAM address width.
- DATA_W, 8, zone brightness width.
- N_ZONES, 576, zones per frame; legal range 1..2**ADDR_W.
- GROUP, 6, bytes per latch group.
- CLK_DIV, 2, sclk half-period in clk cycles; must be >=1.
- LATCH_CYC, 2, latch high width in clk cycles; must be >=1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- frame_start  in  1  one-cycle request to send one frame.
- global_bright  in  8  global brightness scale; used only with the optional feature.
- rd_en  out  1  RAM read strobe.
- rd_addr  out  ADDR_W  RAM read address.
- rd_data  in  DATA_W  RAM read data; valid exactly one cycle after rd_en.
- sclk  out  1  serial clock to the driver chips; idles low.
- sdo  out  1  serial data, MSB first.
- latch  out  1  group latch pulse.
- busy  out  1  high from the cycle after an accepted frame_start until frame_done.
- frame_done  out  1  one-cycle pulse when a frame completes.
- frame_drop  out  1  one-cycle pulse when frame_start arrives while busy.

Behaviour:
- Interface (decided): one clock, clk; reset rst, asynchronous, active-high.
- Reset values: all outputs 0; rd_addr 0; state IDLE; counters 0.
- FSM states: IDLE, RD, WAIT, SHIFT, LATCH, DONE.
- IDLE: frame_start=1 -> RD; zone counter 0, group counter 0; busy=1 next cycle.
- RD: rd_en=1 for one cycle, rd_addr = zone counter -> WAIT.
- WAIT: capture rd_data (scaled if the feature is enabled) into the shift register -> SHIFT.
- SHIFT: 8 bits, MSB first, each bit lasts 2*CLK_DIV cycles.
  - sdo updates at bit start while sclk=0.
  - sclk goes high after CLK_DIV cycles, back low after 2*CLK_DIV.
  - sdo is stable for the whole sclk-high phase.
- After bit 0 of a byte:
  - zone counter +1 and group counter +1.
  - If group counter reached GROUP, or zone counter reached N_ZONES -> LATCH.
  - Otherwise -> RD.
- LATCH: latch=1 for LATCH_CYC cycles with sclk=0; group counter cleared.
  - Then -> DONE if zone counter == N_ZONES, else -> RD.
- DONE: frame_done=1 for one cycle, busy=0 -> IDLE.
- Per-byte cost: 2 + 16*CLK_DIV cycles; sclk stays low between bytes.
- Final group: if N_ZONES is not a multiple of GROUP, the short final group is still latched.
- frame_start while busy (including the DONE cycle): ignored, frame_drop=1 that cycle; no queueing.
- Reset mid-frame: immediate return to IDLE with all outputs low; the next frame starts from zone 0.
- Counter widths: zone counter is ADDR_W+1 bits so N_ZONES = 2**ADDR_W terminates without wrap.
- rd_addr never exceeds N_ZONES-1.

Optional Feature:
- Macro: MINILED_BRIGHT_SCALE_EN.
- Defined: captured byte = (rd_data * global_bright) >> 8, unsigned 16-bit product, upper byte kept.
  - global_bright is sampled at frame_start and held for the whole frame.
  - The result is 0xFF only when neither operand is below 0xFF... more precisely, 255*255 gives 254 (0xFE), so 0xFF is never produced.
- Not defined: rd_data is passed unchanged and global_bright is unused.
- Timing is identical in both builds.

Decomposition:
- Package miniled_pkg holds:
  - FSM state enum (IDLE, RD, WAIT, SHIFT, LATCH, DONE).
  - Default constants: ADDR_W, DATA_W, GROUP, N_ZONES.
- Sub-module miniled_bit_shifter: load strobe, 8-bit parallel load, sclk/sdo generation, CLK_DIV timing, byte_done pulse.
  - The FSM, address generation and latch logic stay in the top.

Test Plan:
- Setup for all cases: RAM model with 1-cycle read latency.
- Full frame: N_ZONES=12, GROUP=6, CLK_DIV=1, RAM[i]=i+0x10, frame_start -> sdo bytes 0x10..0x1B MSB first; latch pulses after bytes 5 and 11 (2 total); frame_done once; busy low after.
- Short final group: N_ZONES=8 -> latch after byte 5 and after byte 7; rd_addr max 7.
- Overlapping request: frame_start again 20 cycles into a frame -> frame_drop=1 for that cycle; frame unchanged; exactly one frame_done.
- Reset mid-frame: assert rst during the SHIFT of byte 3 -> all outputs 0 immediately; after release, frame_start restarts at rd_addr=0.
- Bit timing: CLK_DIV=3, RAM[0]=0xA5 -> sclk high 3 / low 3 cycles; sdo sequence 1,0,1,0,0,1,0,1; sdo stable while sclk=1.
- Brightness scaling (macro defined): global_bright=0x80, RAM[0]=0xFF -> shifted byte 0x7F; global_bright=0x00 -> 0x00. Macro undefined -> 0xFF.
